// File: rtl/card_dealer.sv
// Deal stage after the deck shuffler: buffers one serially loaded deck, checks it
// for duplicate/out-of-range codes, then hands cards out over valid/ready.
module card_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int CARD_W    = 6,
    parameter int CNT_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load_valid,
    input  logic [CARD_W-1:0] load_card,
    output logic              load_ready,
    output logic              deal_valid,
    output logic [CARD_W-1:0] deal_card,
    input  logic              deal_ready,
    output logic [CNT_W-1:0]  cards_left,
    output logic              deck_loaded,
    output logic              load_error,
    output logic              reshuffle_req
);

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        DEAL = 1'b1
    } state_t;

    // The bitmap spans every encodable code so any load_card indexes it safely.
    localparam int SEEN_W = 1 << CARD_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DECK_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DECK_SIZE);
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    wr_ptr_r, wr_ptr_nxt_s;
    logic [CNT_W-1:0]    rd_ptr_r, rd_ptr_nxt_s;
    logic [CNT_W-1:0]    cards_left_r, cards_left_nxt_s;
    logic [SEEN_W-1:0]   seen_r, seen_nxt_s;
    logic                load_error_r, load_error_nxt_s;
    logic                reshuffle_r, reshuffle_nxt_s;
    logic [CARD_W-1:0]   mem_r [DECK_SIZE];

    logic                load_acc_s;
    logic                deal_acc_s;
    logic                deal_valid_s;
    logic                in_range_s;
    logic [SEEN_W-1:0]   card_onehot_s;

    assign deal_valid_s  = (state_r == DEAL) && (cards_left_r != {CNT_W{1'b0}});
    assign load_acc_s    = load_valid && (state_r == LOAD);
    assign deal_acc_s    = deal_valid_s && deal_ready;
    assign in_range_s    = (32'(load_card) < DECK_SIZE);
    assign card_onehot_s = {{(SEEN_W-1){1'b0}}, 1'b1} << load_card;

    assign load_ready    = (state_r == LOAD);
    assign deck_loaded   = (state_r == DEAL);
    assign deal_valid    = deal_valid_s;
    assign deal_card     = deal_valid_s ? mem_r[rd_ptr_r] : {CARD_W{1'b0}};
    assign cards_left    = cards_left_r;
    assign load_error    = load_error_r;
    assign reshuffle_req = reshuffle_r;

    // Next-state and counter update; flush overrides any accept in the same cycle.
    always_comb begin
        state_nxt_s      = state_r;
        wr_ptr_nxt_s     = wr_ptr_r;
        rd_ptr_nxt_s     = rd_ptr_r;
        cards_left_nxt_s = cards_left_r;
        seen_nxt_s       = seen_r;
        load_error_nxt_s = load_error_r;
        reshuffle_nxt_s  = 1'b0;
        if (flush) begin
            state_nxt_s      = LOAD;
            wr_ptr_nxt_s     = {CNT_W{1'b0}};
            rd_ptr_nxt_s     = {CNT_W{1'b0}};
            cards_left_nxt_s = {CNT_W{1'b0}};
            seen_nxt_s       = {SEEN_W{1'b0}};
            load_error_nxt_s = 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (load_acc_s) begin
                        if (!in_range_s || ((seen_r & card_onehot_s) != {SEEN_W{1'b0}})) begin
                            load_error_nxt_s = 1'b1;
                        end else begin
                            load_error_nxt_s = load_error_r;
                        end
                        if (in_range_s) begin
                            seen_nxt_s = seen_r | card_onehot_s;
                        end else begin
                            seen_nxt_s = seen_r;
                        end
                        if (wr_ptr_r == LAST_IDX) begin
                            state_nxt_s      = DEAL;
                            wr_ptr_nxt_s     = {CNT_W{1'b0}};
                            rd_ptr_nxt_s     = {CNT_W{1'b0}};
                            cards_left_nxt_s = FULL_CNT;
                        end else begin
                            wr_ptr_nxt_s = wr_ptr_r + ONE_CNT;
                        end
                    end else begin
                        wr_ptr_nxt_s = wr_ptr_r;
                    end
                end
                DEAL: begin
                    if (deal_acc_s) begin
                        if (cards_left_r == ONE_CNT) begin
                            // Last card: rd_ptr returns to 0 so it never passes DECK_SIZE-1.
                            state_nxt_s      = LOAD;
                            rd_ptr_nxt_s     = {CNT_W{1'b0}};
                            cards_left_nxt_s = {CNT_W{1'b0}};
                            seen_nxt_s       = {SEEN_W{1'b0}};
                            reshuffle_nxt_s  = 1'b1;
                        end else begin
                            rd_ptr_nxt_s     = rd_ptr_r + ONE_CNT;
                            cards_left_nxt_s = cards_left_r - ONE_CNT;
                        end
                    end else begin
                        rd_ptr_nxt_s = rd_ptr_r;
                    end
                end
                default: begin
                    state_nxt_s = LOAD;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= LOAD;
            wr_ptr_r     <= {CNT_W{1'b0}};
            rd_ptr_r     <= {CNT_W{1'b0}};
            cards_left_r <= {CNT_W{1'b0}};
            seen_r       <= {SEEN_W{1'b0}};
            load_error_r <= 1'b0;
            reshuffle_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            cards_left_r <= cards_left_nxt_s;
            seen_r       <= seen_nxt_s;
            load_error_r <= load_error_nxt_s;
            reshuffle_r  <= reshuffle_nxt_s;
        end
    end

    // Deck buffer; contents are meaningless until a full deck has been written.
    always_ff @(posedge clk) begin
        if (load_acc_s && !flush) begin
            mem_r[wr_ptr_r] <= load_card;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Randomized bench for card_dealer, checked cycle by cycle against a queue-based
// model of the deck (load list, deal list, seen set, sticky error).
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       load_valid = 1'b0;
    logic [5:0] load_card = 6'd0;
    logic       load_ready;
    logic       deal_valid;
    logic [5:0] deal_card;
    logic       deal_ready = 1'b0;
    logic [5:0] cards_left;
    logic       deck_loaded;
    logic       load_error;
    logic       reshuffle_req;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    bit      m_loading;
    int      m_loadq[$];
    int      m_dealq[$];
    bit      m_seen[64];
    bit      m_err;
    bit      m_resh;
    int      deck_a[52];

    card_dealer #(.DECK_SIZE(52), .CARD_W(6), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .load_valid(load_valid), .load_card(load_card), .load_ready(load_ready),
        .deal_valid(deal_valid), .deal_card(deal_card), .deal_ready(deal_ready),
        .cards_left(cards_left), .deck_loaded(deck_loaded),
        .load_error(load_error), .reshuffle_req(reshuffle_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b1;
        m_loadq.delete();
        m_dealq.delete();
        foreach (m_seen[i]) m_seen[i] = 1'b0;
        m_err  = 1'b0;
        m_resh = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".load_ready"},    int'(load_ready),    int'(m_loading));
        check({tag, ".deal_valid"},    int'(deal_valid),    int'(!m_loading));
        check({tag, ".deck_loaded"},   int'(deck_loaded),   int'(!m_loading));
        check({tag, ".cards_left"},    int'(cards_left),    m_loading ? 0 : m_dealq.size());
        check({tag, ".deal_card"},     int'(deal_card),     m_loading ? 0 : m_dealq[0]);
        check({tag, ".load_error"},    int'(load_error),    int'(m_err));
        check({tag, ".reshuffle_req"}, int'(reshuffle_req), int'(m_resh));
    endtask

    // One clock: the model applies the deck rules to the inputs seen at the edge.
    task automatic step(input string tag);
        @(posedge clk);
        m_resh = 1'b0;
        if (flush) begin
            model_reset();
        end else if (m_loading) begin
            if (load_valid) begin
                if (load_card >= 6'd52 || m_seen[load_card]) m_err = 1'b1;
                if (load_card < 6'd52) m_seen[load_card] = 1'b1;
                m_loadq.push_back(int'(load_card));
                if (m_loadq.size() == 52) begin
                    m_dealq = m_loadq;
                    m_loadq.delete();
                    m_loading = 1'b0;
                end
            end
        end else if (deal_ready) begin
            void'(m_dealq.pop_front());
            if (m_dealq.size() == 0) begin
                m_loading = 1'b1;
                foreach (m_seen[i]) m_seen[i] = 1'b0;
                m_resh = 1'b1;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic fill_desc();
        for (int i = 0; i < 52; i++) deck_a[i] = 51 - i;
    endtask

    task automatic fill_shuffle();
        int j, t;
        for (int i = 0; i < 52; i++) deck_a[i] = i;
        for (int i = 51; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = deck_a[i]; deck_a[i] = deck_a[j]; deck_a[j] = t;
        end
    endtask

    // Streams deck_a[0..n-1]; rand_v gaps load_valid randomly.
    task automatic load_n(input int n, input bit rand_v, input string tag);
        int i = 0;
        int budget = 2000;
        while (i < n && budget > 0) begin
            load_valid = rand_v ? 1'($urandom_range(1, 0)) : 1'b1;
            load_card  = 6'(deck_a[i]);
            if (load_valid && m_loading) i++;
            step(tag);
            budget--;
        end
        load_valid = 1'b0;
        if (i < n) check({tag, ".load_timeout"}, i, n);
    endtask

    task automatic deal_n(input int n, input bit rand_r, input string tag);
        int i = 0;
        int budget = 2000;
        while (i < n && budget > 0) begin
            deal_ready = rand_r ? 1'($urandom_range(1, 0)) : 1'b1;
            if (deal_ready && !m_loading) i++;
            step(tag);
            budget--;
        end
        deal_ready = 1'b0;
        if (i < n) check({tag, ".deal_timeout"}, i, n);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".load_ready"},    int'(load_ready),    1);
        check({tag, ".deal_valid"},    int'(deal_valid),    0);
        check({tag, ".deck_loaded"},   int'(deck_loaded),   0);
        check({tag, ".cards_left"},    int'(cards_left),    0);
        check({tag, ".deal_card"},     int'(deal_card),     0);
        check({tag, ".load_error"},    int'(load_error),    0);
        check({tag, ".reshuffle_req"}, int'(reshuffle_req), 0);
    endtask

    initial begin
        model_reset();
        #23;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Descending deck, valid and ready held high.
        fill_desc();
        deal_ready = 1'b1;
        load_n(52, 1'b0, "desc_load");
        check("desc_cards_left", int'(cards_left), 52);
        deal_n(52, 1'b0, "desc_deal");
        check("desc_resh_pulse", int'(reshuffle_req), 1);
        step("desc_idle");
        check("desc_resh_once", int'(reshuffle_req), 0);

        // Shuffled deck with random valid gaps and random ready.
        fill_shuffle();
        load_n(52, 1'b1, "rand_load");
        deal_n(52, 1'b1, "rand_deal");
        step("rand_idle");

        // Duplicate 7 and out-of-range 60; error survives deal and reload.
        fill_desc();
        deck_a[10] = 7;
        deck_a[30] = 60;
        load_n(52, 1'b1, "dup_load");
        check("dup_error_set", int'(load_error), 1);
        deal_n(52, 1'b0, "dup_deal");
        fill_shuffle();
        load_n(52, 1'b0, "dup_reload");
        check("dup_error_kept", int'(load_error), 1);
        flush = 1'b1;
        step("dup_flush");
        flush = 1'b0;
        check("dup_error_clr", int'(load_error), 0);

        // Flush part-way through a load, then a fresh deck.
        fill_shuffle();
        load_n(20, 1'b0, "pflush_load");
        flush = 1'b1; load_valid = 1'b1; load_card = 6'd3;
        step("pflush");
        flush = 1'b0; load_valid = 1'b0;
        fill_shuffle();
        load_n(52, 1'b1, "pflush_reload");
        deal_n(52, 1'b1, "pflush_deal");
        step("pflush_idle");

        // Flush with 10 cards left and ready held high.
        fill_shuffle();
        load_n(52, 1'b0, "dflush_load");
        deal_n(42, 1'b0, "dflush_deal");
        check("dflush_left10", int'(cards_left), 10);
        flush = 1'b1; deal_ready = 1'b1;
        step("dflush");
        flush = 1'b0;
        for (int k = 0; k < 3; k++) step("dflush_after");
        deal_ready = 1'b0;

        // Asynchronous reset mid-deal with 30 cards left.
        fill_shuffle();
        load_n(52, 1'b1, "arst_load");
        deal_n(22, 1'b0, "arst_deal");
        check("arst_left30", int'(cards_left), 30);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("arst_release");
        fill_shuffle();
        load_n(52, 1'b0, "arst_reload");
        deal_n(52, 1'b1, "arst_redeal");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Deal stage directly downstream of the deck shuffler.
- Accepts a shuffled deck as a serial stream of DECK_SIZE card codes and stores it in an internal deck buffer.
- Hands cards out one at a time to game logic over a valid/ready handshake.
- Tracks the remaining card count, checks the loaded deck for duplicate or out-of-range codes, and pulses a reshuffle request when the deck is exhausted.

Parameters:
- DECK_SIZE, 52, number of cards per deck; cards are coded 0..DECK_SIZE-1.
- CARD_W, 6, width of a card code; must satisfy 2^CARD_W >= DECK_SIZE.
- CNT_W, 6, width of pointers and counters; must satisfy 2^CNT_W > DECK_SIZE.

Ports:
- clk, input, 1, the single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous discard of the current deck; returns the block to loading.
- load_valid, input, 1, upstream card available on load_card.
- load_card, input, CARD_W, card code from the shuffler.
- load_ready, output, 1, block accepts a card this cycle.
- deal_valid, output, 1, deal_card holds the next card.
- deal_card, output, CARD_W, card at the top of the deck.
- deal_ready, input, 1, consumer takes the card this cycle.
- cards_left, output, CNT_W, cards remaining to deal.
- deck_loaded, output, 1, a full deck is held; equals 1 exactly when the state is DEAL.
- load_error, output, 1, sticky flag: a duplicate or out-of-range code was loaded.
- reshuffle_req, output, 1, one-cycle pulse when the last card is dealt.

Behaviour:
- Reset values:
  - state = LOAD; wr_ptr = 0; rd_ptr = 0.
  - cards_left = 0; seen bitmap cleared.
  - load_ready = 1; deal_valid = 0; deck_loaded = 0.
  - load_error = 0; reshuffle_req = 0; deal_card = 0.
- State machine: two states, LOAD and DEAL.
- LOAD state:
  - load_ready = 1 and deal_valid = 0.
  - Load accept = load_valid && load_ready. Each accept writes mem[wr_ptr] = load_card, then increments wr_ptr.
  - If load_card >= DECK_SIZE, or seen[load_card] is already set, load_error is set. The card is still stored.
  - When the card code is in range, seen[load_card] is set on accept.
  - The accept with wr_ptr == DECK_SIZE-1 completes the deck. On the next cycle: state = DEAL, wr_ptr = 0, rd_ptr = 0, cards_left = DECK_SIZE, deck_loaded = 1.
- DEAL state:
  - load_ready = 0; incoming load_valid is ignored and backpressured.
  - deal_valid = 1 while cards_left != 0.
  - deal_card = mem[rd_ptr], combinational read. It is stable while deal_valid && !deal_ready.
  - Deal accept = deal_valid && deal_ready. Each accept increments rd_ptr and decrements cards_left.
  - The accept that takes cards_left from 1 to 0 does three things on the next cycle:
    - reshuffle_req pulses high for exactly one cycle;
    - state returns to LOAD, with deck_loaded = 0 and load_ready = 1;
    - the seen bitmap is cleared.
  - load_error persists across this transition. It is cleared only by flush or reset.
- Latency:
  - The first deal is offered one cycle after the last load accept.
  - With deal_ready held at 1, one card is dealt per cycle, and the full deck takes DECK_SIZE cycles.
  - The block becomes reloadable on the cycle in which reshuffle_req is high.
- Flush:
  - Highest priority. On the next edge the block is in LOAD state with wr_ptr = rd_ptr = 0, cards_left = 0, seen cleared, load_error = 0 and deck_loaded = 0.
  - A load accept or deal accept in the same cycle as flush is discarded.
  - Flush does not raise reshuffle_req.
- Reset mid-operation: asynchronously forces all reset values, whether the block is partway through a load or a deal. Buffer contents are don't-care after reset.
- No deal is ever offered from a partially loaded deck.
- Pointers never exceed DECK_SIZE-1. There is no wrap-around inside a deck.

Test Plan:
- Reset, then stream codes 51,50,...,0 with load_valid held at 1 → load_ready drops after 52 accepts, deck_loaded = 1, cards_left = 52. With deal_ready = 1, cards emerge 51..0 on consecutive cycles, reshuffle_req pulses once after card 0, and load_error stays 0.
- Full load, then toggle deal_ready randomly → deal_card is held stable whenever deal_ready = 0, all 52 cards come out in load order, and cards_left decrements only on accepts.
- Load with code 7 appearing twice and code 60 once → load_error = 1 after the offending accepts. It stays 1 through a full deal and the reload, then clears after a flush.
- Assert flush after 20 loaded cards → next cycle wr_ptr = 0 and deck_loaded = 0. A fresh 52-card load then deals correctly.
- Assert flush with cards_left = 10 while deal_ready = 1 → no further deals, cards_left = 0, no reshuffle_req, load_ready = 1.
- Assert rst_n low asynchronously mid-deal (cards_left = 30) → outputs reach reset values immediately without waiting for a clock edge. After release, load_ready = 1.
